mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_load_ext.sv | 28 ++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the LoongArch memory stage: EX->MS bus field offsets,
// load-op encodings and the MEM stage state encoding.
package mem_stage_pkg;

  localparam int ALU_LSB          = 32;
  localparam int DEST_LSB         = 64;
  localparam int GR_WE_BIT        = 69;
  localparam int RES_FROM_CSR_BIT = 70;
  localparam int EXCP_BIT         = 71;
  localparam int ERTN_BIT         = 167;
  localparam int RES_FROM_MEM_BIT = 168;
  localparam int LOAD_OP_LSB      = 169;
  localparam int MEM_REQ_BIT      = 172;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } load_op_e;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_HOLD  = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extractor: selects the addressed byte/halfword of a loaded word and
// sign- or zero-extends it; unknown load ops fall back to a full-word load.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  off,
  input  logic [31:0] src,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(src >> {off, 3'b000});
  assign half_sel = 16'(src >> {off[1], 4'b0000});

  always_comb begin
    case (load_op_e'(load_op))
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h0, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0, half_sel};
      default: result = src;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// LoongArch MEM stage: waits for the data-SRAM response of loads/stores issued in
// EX, extends load data, forwards results to ID and hands the bus to WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ES_TO_MS_BUS_WD = 173,
  parameter int MS_TO_WS_BUS_WD = 168,
  parameter int MS_FORWARD_WD   = 41
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  output logic                       ms_ex,
  input  logic                       excp_flush,
  input  logic                       ertn_flush
);

  ms_state_e                  state_q, state_d;
  logic                       cancel_q, cancel_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;

  logic        ms_valid, in_wait, flush, own_ok, ms_ready_go, accept;
  logic [31:0] alu_result, load_result, final_result;
  logic        res_from_mem;

  assign ms_valid = (state_q != MS_EMPTY);
  assign in_wait  = (state_q == MS_WAIT);
  assign flush    = excp_flush | ertn_flush;
  // A strobe seen while cancel is set belongs to a flushed load, not to us.
  assign own_ok   = data_sram_data_ok & ~cancel_q;

  assign ms_ready_go    = (state_q == MS_HOLD) | (in_wait & own_ok);
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
  assign accept         = es_to_ms_valid & ms_allowin & ~flush;

  assign alu_result   = bus_q[ALU_LSB +: 32];
  assign res_from_mem = bus_q[RES_FROM_MEM_BIT];

  mem_load_ext u_load_ext (
    .load_op (bus_q[LOAD_OP_LSB +: 3]),
    .off     (alu_result[1:0]),
    .src     (in_wait ? data_sram_rdata : rdata_buf_q),
    .result  (load_result)
  );

  assign final_result = res_from_mem ? load_result : alu_result;

  assign ms_to_ws_bus = {bus_q[MS_TO_WS_BUS_WD-1:DEST_LSB], final_result, bus_q[31:0]};
  assign ms_ex        = ms_valid & (bus_q[EXCP_BIT] | bus_q[ERTN_BIT]);

  assign ms_forward = {
    ms_valid & (bus_q[RES_FROM_CSR_BIT] | bus_q[EXCP_BIT] | bus_q[ERTN_BIT]),
    ms_valid & res_from_mem & ~ms_ready_go,
    final_result,
    bus_q[DEST_LSB +: 5],
    ms_valid & bus_q[GR_WE_BIT],
    ms_valid
  };

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d     = state_q;
    cancel_d    = cancel_q;
    bus_d       = bus_q;
    rdata_buf_d = own_ok ? data_sram_rdata : rdata_buf_q;

    if (cancel_q && data_sram_data_ok) cancel_d = 1'b0;

    if (flush) begin
      state_d = MS_EMPTY;
      if (in_wait && !own_ok) cancel_d = 1'b1;
    end else if (accept) begin
      bus_d = es_to_ms_bus;
      // A response can only belong to the incoming op if nothing is waiting here.
      if (!es_to_ms_bus[MEM_REQ_BIT] || (own_ok && !in_wait)) state_d = MS_HOLD;
      else                                                   state_d = MS_WAIT;
    end else if (ms_to_ws_valid && ws_allowin) begin
      state_d = MS_EMPTY;
    end else if (in_wait && own_ok) begin
      state_d = MS_HOLD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the data buffer and
  // payload are reset too so the forward/bus outputs read zero out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= MS_EMPTY;
      cancel_q    <= 1'b0;
      rdata_buf_q <= '0;
      bus_q       <= '0;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      rdata_buf_q <= rdata_buf_d;
      bus_q       <= bus_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load-extension table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [172:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [167:0] ms_to_ws_bus;
  logic         data_ok;
  logic [31:0]  rdata;
  logic [40:0]  ms_forward;
  logic         ms_ex;
  logic         excp_flush;
  logic         ertn_flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_forward        (ms_forward),
    .ms_ex             (ms_ex),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [172:0] mk(input logic [31:0] pc, input logic [31:0] addr,
                                      input logic [4:0] dest, input logic gr_we,
                                      input logic res_csr, input logic excp, input logic ertn,
                                      input logic res_mem, input logic [2:0] op,
                                      input logic mem_req);
    logic [172:0] b;
    b = '0;
    b[31:0]    = pc;
    b[63:32]   = addr;
    b[68:64]   = dest;
    b[69]      = gr_we;
    b[70]      = res_csr;
    b[71]      = excp;
    b[167]     = ertn;
    b[168]     = res_mem;
    b[171:169] = op;
    b[172]     = mem_req;
    return b;
  endfunction

  // Reference extension from the load rules, using shifts and masks on the word.
  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] v;
    int unsigned hoff;
    hoff = (off >= 2) ? 16 : 0;
    case (op)
      3'b001: begin v = (w >> (8 * off)) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'b101: v = (w >> (8 * off)) & 32'hFF;
      3'b010: begin v = (w >> hoff) & 32'hFFFF;      if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'b110: v = (w >> hoff) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic idle();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    ws_allowin     = 1'b1;
    data_ok        = 1'b0;
    rdata          = '0;
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vec[12];

  // Random-run model state
  bit           occ, have_data;
  logic [172:0] m_bus;
  logic [31:0]  m_data;
  int           stale, cyc, last_due;
  int           due_q[$];
  logic [31:0]  rd_q[$];

  initial begin
    vec[0]  = '{3'b001, 32'h1003, 32'h8012_3456, 32'hFFFF_FF80};
    vec[1]  = '{3'b101, 32'h1003, 32'h8012_3456, 32'h0000_0080};
    vec[2]  = '{3'b001, 32'h1000, 32'h8012_3456, 32'h0000_0056};
    vec[3]  = '{3'b001, 32'h1001, 32'h8012_3456, 32'h0000_0034};
    vec[4]  = '{3'b101, 32'h1002, 32'h00F0_0000, 32'h0000_00F0};
    vec[5]  = '{3'b001, 32'h1002, 32'h00F0_0000, 32'hFFFF_FFF0};
    vec[6]  = '{3'b010, 32'h2000, 32'h1234_ABCD, 32'hFFFF_ABCD};
    vec[7]  = '{3'b010, 32'h2002, 32'h1234_ABCD, 32'h0000_1234};
    vec[8]  = '{3'b110, 32'h2000, 32'h1234_ABCD, 32'h0000_ABCD};
    vec[9]  = '{3'b000, 32'h3000, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vec[10] = '{3'b011, 32'h3001, 32'h8765_4321, 32'h8765_4321};
    vec[11] = '{3'b111, 32'h3002, 32'h8765_4321, 32'h8765_4321};

    idle();
    resetn = 1'b0;
    #12;
    check("rst_allowin", ms_allowin, 1);
    check("rst_valid", ms_to_ws_valid, 0);
    check("rst_forward", ms_forward, 0);
    check("rst_ex", ms_ex, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed load extension, response one cycle after acceptance
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(32'h100 + 32'(i * 4), vec[i].addr, 5'd3, 1, 0, 0, 0, 1, vec[i].op, 1);
      #1 check($sformatf("tbl%0d_allowin", i), ms_allowin, 1);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      data_ok = 1'b1;
      rdata   = vec[i].rdata;
      #1;
      check($sformatf("tbl%0d_valid", i), ms_to_ws_valid, 1);
      check($sformatf("tbl%0d_result", i), ms_to_ws_bus[63:32], vec[i].exp);
      @(negedge clk);
      data_ok = 1'b0;
      #1 check($sformatf("tbl%0d_empty", i), ms_to_ws_valid, 0);
    end

    // ld.hu with a 3-cycle response delay
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h200, 32'h2002, 5'd4, 1, 0, 0, 0, 1, 3'b110, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      #1;
      check($sformatf("hu_pending%0d", i), ms_forward[39], 1);
      check($sformatf("hu_novalid%0d", i), ms_to_ws_valid, 0);
    end
    @(negedge clk);
    data_ok = 1'b1;
    rdata   = 32'hABCD_1234;
    #1;
    check("hu_valid", ms_to_ws_valid, 1);
    check("hu_result", ms_to_ws_bus[63:32], 32'h0000_ABCD);
    check("hu_pending_clear", ms_forward[39], 0);
    @(negedge clk);
    idle();

    // Back-to-back ALU ops
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h300, 32'h55, 5'd5, 1, 0, 0, 0, 0, 3'b000, 0);
    #1 check("alu_allow0", ms_allowin, 1);
    @(negedge clk);
    es_to_ms_bus = mk(32'h304, 32'h66, 5'd6, 1, 0, 0, 0, 0, 3'b000, 0);
    #1;
    check("alu_valid0", ms_to_ws_valid, 1);
    check("alu_res0", ms_to_ws_bus[63:32], 32'h55);
    check("alu_allow1", ms_allowin, 1);
    check("alu_fwd0", ms_forward, {1'b0, 1'b0, 32'h55, 5'd5, 1'b1, 1'b1});
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    check("alu_valid1", ms_to_ws_valid, 1);
    check("alu_res1", ms_to_ws_bus[63:32], 32'h66);
    @(negedge clk);
    #1 check("alu_empty", ms_to_ws_valid, 0);

    // Flush in WAIT, then a new load: first strobe is discarded
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h400, 32'h4000, 5'd7, 1, 0, 0, 0, 1, 3'b000, 1);
    @(negedge clk);
    es_to_ms_bus = mk(32'h404, 32'h5000, 5'd8, 1, 0, 0, 0, 1, 3'b000, 1);
    excp_flush   = 1'b1;
    #1;
    check("fl_novalid", ms_to_ws_valid, 0);
    check("fl_noallow", ms_allowin, 0);
    @(negedge clk);
    excp_flush = 1'b0;
    #1;
    check("fl_allow", ms_allowin, 1);
    check("fl_empty", ms_to_ws_valid, 0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_ok = 1'b1;
    rdata   = 32'h1111_1111;
    #1;
    check("fl_stale_novalid", ms_to_ws_valid, 0);
    check("fl_stale_pending", ms_forward[39], 1);
    @(negedge clk);
    rdata = 32'h2222_2222;
    #1;
    check("fl_own_valid", ms_to_ws_valid, 1);
    check("fl_own_result", ms_to_ws_bus[63:32], 32'h2222_2222);
    @(negedge clk);
    data_ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h408, 32'h6000, 5'd9, 1, 0, 0, 0, 1, 3'b000, 1);
    #1 check("fl_after_empty", ms_to_ws_valid, 0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_ok = 1'b1;
    rdata   = 32'h3333_3333;
    #1;
    check("fl_cancel_clear_valid", ms_to_ws_valid, 1);
    check("fl_cancel_clear_res", ms_to_ws_bus[63:32], 32'h3333_3333);
    @(negedge clk);
    idle();

    // Response while WB stalls for 2 cycles
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h500, 32'h7000, 5'd10, 1, 0, 0, 0, 1, 3'b000, 1);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata      = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("st%0d_valid", i), ms_to_ws_valid, 1);
      check($sformatf("st%0d_result", i), ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
      check($sformatf("st%0d_noallow", i), ms_allowin, 0);
      @(negedge clk);
      data_ok = 1'b0;
      rdata   = 32'h0;
    end
    ws_allowin = 1'b1;
    #1;
    check("st_deliver_valid", ms_to_ws_valid, 1);
    check("st_deliver_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
    check("st_deliver_allow", ms_allowin, 1);
    @(negedge clk);
    #1 check("st_empty", ms_to_ws_valid, 0);

    // Randomized run against the transaction-level model
    occ = 0; have_data = 0; stale = 0; cyc = 0; last_due = 0; m_bus = '0; m_data = '0;
    for (int n = 0; n < 2000; n++) begin
      bit own, ready, e_valid, e_allow, waiting, flush, acc, tail;
      logic [31:0] src, e_res;
      int due;
      @(negedge clk);
      tail = (n >= 1960);
      ws_allowin = tail ? 1'b1 : ($urandom_range(0, 3) != 0);
      excp_flush = 1'b0;
      ertn_flush = 1'b0;
      if (!tail && stale == 0 && $urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) excp_flush = 1'b1; else ertn_flush = 1'b1;
      end
      es_to_ms_valid = tail ? 1'b0 : 1'($urandom_range(0, 1));
      begin
        int kind;
        logic [172:0] b;
        kind = $urandom_range(0, 2);
        b = mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               kind == 1, 3'($urandom), kind != 0);
        b[166:72] = {$urandom, $urandom, $urandom};
        es_to_ms_bus = b;
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        data_ok = 1'b1;
        rdata   = rd_q[0];
        void'(due_q.pop_front());
        void'(rd_q.pop_front());
      end else begin
        data_ok = 1'b0;
        rdata   = $urandom;
      end
      flush = excp_flush | ertn_flush;

      own     = data_ok && (stale == 0);
      waiting = occ && m_bus[172] && !have_data;
      ready   = occ && (!m_bus[172] || have_data || own);
      e_valid = ready && !flush;
      e_allow = !occ || (ready && ws_allowin);
      src     = have_data ? m_data : rdata;
      e_res   = m_bus[168] ? ref_ext(m_bus[171:169], m_bus[33:32], src) : m_bus[63:32];

      #1;
      check("rnd_valid", ms_to_ws_valid, e_valid);
      check("rnd_allowin", ms_allowin, e_allow);
      check("rnd_ex", ms_ex, occ && (m_bus[71] || m_bus[167]));
      check("rnd_fwd_valid", ms_forward[0], occ);
      if (occ) begin
        check("rnd_fwd_pending", ms_forward[39], m_bus[168] && !ready);
        check("rnd_fwd_csr", ms_forward[40], m_bus[70] || m_bus[71] || m_bus[167]);
        if (ready) check("rnd_fwd_result", ms_forward[38:7], e_res);
      end
      if (e_valid) check("rnd_bus", ms_to_ws_bus[167:0], {m_bus[167:64], e_res, m_bus[31:0]});

      if (data_ok) begin
        if (stale > 0) stale--;
        else if (waiting) begin have_data = 1; m_data = rdata; end
      end
      if (flush) begin
        if (waiting && !own) stale++;
        occ = 0;
      end else begin
        acc = es_to_ms_valid && e_allow;
        if (e_valid && ws_allowin) occ = 0;
        if (acc) begin
          occ = 1;
          m_bus = es_to_ms_bus;
          have_data = 0;
          if (es_to_ms_bus[172]) begin
            due = cyc + 1 + $urandom_range(0, 3);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
            rd_q.push_back($urandom);
          end
        end
      end
      cyc++;
    end
    @(negedge clk);
    idle();
    #1 check("rnd_drained", ms_forward[0], 0);

    // Reset during a cancelled wait, then normal load
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h600, 32'h8000, 5'd11, 1, 0, 0, 0, 1, 3'b000, 1);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h604, 32'h8004, 5'd12, 1, 0, 1, 0, 1, 3'b000, 1);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1 check("rw_ex_before", ms_ex, 1);
    resetn = 1'b0;
    #1;
    check("rw_allowin", ms_allowin, 1);
    check("rw_valid", ms_to_ws_valid, 0);
    check("rw_forward", ms_forward, 0);
    check("rw_ex", ms_ex, 0);
    @(negedge clk);
    resetn = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h608, 32'h8008, 5'd13, 1, 0, 0, 0, 1, 3'b000, 1);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_ok = 1'b1;
    rdata   = 32'h1357_2468;
    #1;
    check("rw_post_valid", ms_to_ws_valid, 1);
    check("rw_post_result", ms_to_ws_bus[63:32], 32'h1357_2468);
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
